// File: rtl/fetch_decode_buffer_if.sv
// fetch_decode_buffer_if
//   Bundles the IF/ID handshake, hazard control and decode-side outputs of
//   fetch_decode_buffer.
//   master : fetch/hazard side (drives in_*, stall, flush; observes outputs)
//   slave  : the buffer itself
// Parameters: PC_W program-counter width, BCNT_W bubble-counter width.
interface fetch_decode_buffer_if #(
  parameter int PC_W   = 32,
  parameter int BCNT_W = 16
);
  logic              in_valid;
  logic [15:0]       in_word;
  logic [PC_W-1:0]   in_pc;
  logic              stall;
  logic              flush;
  logic              in_ready;
  logic              out_valid;
  logic [15:0]       out_instr;
  logic [15:0]       out_imm;
  logic [PC_W-1:0]   out_pc;
  logic [4:0]        out_read_addr1;
  logic [4:0]        out_read_addr2;
  logic [BCNT_W-1:0] bubble_cnt;

  modport master (
    output in_valid, in_word, in_pc, stall, flush,
    input  in_ready, out_valid, out_instr, out_imm, out_pc,
           out_read_addr1, out_read_addr2, bubble_cnt
  );

  modport slave (
    input  in_valid, in_word, in_pc, stall, flush,
    output in_ready, out_valid, out_instr, out_imm, out_pc,
           out_read_addr1, out_read_addr2, bubble_cnt
  );
endinterface

// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer
//   IF/ID pipeline register. Captures 16-bit words from fetch, pairs an
//   opcode word whose top two bits are 2'b11 with the following immediate
//   word, and presents a complete instruction, its PC and the register-file
//   read addresses to decode. stall freezes everything; flush (which wins
//   over stall) drops the held/partial instruction and any word offered in
//   the same cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-low reset
//   fd   - fetch_decode_buffer_if.slave (in_*, stall, flush, in_ready,
//          out_*, bubble_cnt)
// Optional feature: define FD_BUBBLE_CNT_EN to build a saturating counter of
//   cycles in which no instruction was presented (out_valid written 0 while
//   the stage advances). Without it bubble_cnt is tied to 0.
module fetch_decode_buffer #(
  parameter int PC_W   = 32,
  parameter int BCNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_decode_buffer_if.slave  fd
);

  typedef enum logic {S_FIRST, S_IMM} state_t;

  state_t          state, state_nxt;
  logic            in_ready, accept, two_word;
  logic            ld_single, ld_hold, ld_pair, valid_nxt;
  logic [15:0]     hold_instr;
  logic [PC_W-1:0] hold_pc;

  // The stage advances whenever it is not stalled, or when a flush forces it.
  assign in_ready    = ~fd.stall | fd.flush;
  assign fd.in_ready = in_ready;
  assign accept      = fd.in_valid & in_ready;
  assign two_word    = (fd.in_word[15:14] == 2'b11);

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FIRST;
    else      state <= state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    if (fd.flush) begin
      state_nxt = S_FIRST;
    end else if (accept) begin
      case (state)
        S_FIRST: if (two_word) state_nxt = S_IMM;
        S_IMM:   state_nxt = S_FIRST;
        default: state_nxt = S_FIRST;
      endcase
    end
  end

  // ---- FSM: outputs (datapath load strobes) ----
  // In S_IMM the word is pure data, so its top bits are never decoded.
  always_comb begin
    ld_single = 1'b0;
    ld_hold   = 1'b0;
    ld_pair   = 1'b0;
    if (accept && !fd.flush) begin
      case (state)
        S_FIRST: begin
          ld_single = ~two_word;
          ld_hold   = two_word;
        end
        S_IMM:   ld_pair = 1'b1;
        default: ;
      endcase
    end
  end

  assign valid_nxt = ld_single | ld_pair;

  // ---- datapath ----
  // On flush out_instr/out_imm/out_pc keep their contents; only valid drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fd.out_valid <= 1'b0;
      fd.out_instr <= '0;
      fd.out_imm   <= '0;
      fd.out_pc    <= '0;
      hold_instr   <= '0;
      hold_pc      <= '0;
    end else begin
      if (in_ready) fd.out_valid <= valid_nxt;
      if (ld_single) begin
        fd.out_instr <= fd.in_word;
        fd.out_imm   <= '0;
        fd.out_pc    <= fd.in_pc;
      end
      if (ld_pair) begin
        fd.out_instr <= hold_instr;
        fd.out_imm   <= fd.in_word;
        fd.out_pc    <= hold_pc;
      end
      if (ld_hold) begin
        hold_instr <= fd.in_word;
        hold_pc    <= fd.in_pc;
      end else if (fd.flush) begin
        hold_instr <= '0;
        hold_pc    <= '0;
      end
    end
  end

  assign fd.out_read_addr1 = {2'b00, fd.out_instr[10:8]};
  assign fd.out_read_addr2 = {2'b00, fd.out_instr[7:5]};

`ifdef FD_BUBBLE_CNT_EN
  logic [BCNT_W-1:0] bcnt_q;

  // A bubble is any advancing edge that writes out_valid to 0 (flush too).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bcnt_q <= '0;
    else if (in_ready && !valid_nxt && (bcnt_q != {BCNT_W{1'b1}}))
      bcnt_q <= bcnt_q + 1'b1;
  end

  assign fd.bubble_cnt = bcnt_q;
`else
  assign fd.bubble_cnt = {BCNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Scoreboard bench for fetch_decode_buffer: the stimulus process predicts
// each complete instruction as words are offered and queues it; a negedge
// monitor pops one entry each time decode consumes a presented instruction
// (out_valid while the stage advances) and compares every output field.
module tb_fetch_decode_buffer;
  localparam int PC_W   = 32;
  localparam int BCNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_decode_buffer_if #(.PC_W(PC_W), .BCNT_W(BCNT_W)) fd();

  fetch_decode_buffer #(.PC_W(PC_W), .BCNT_W(BCNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .fd  (fd)
  );

  typedef struct {
    logic [15:0]     instr;
    logic [15:0]     imm;
    logic [PC_W-1:0] pc;
  } exp_t;

  exp_t            q[$];
  int              vectors = 0;
  int              errors  = 0;
  bit              pend    = 1'b0;
  logic [15:0]     hold_w;
  logic [PC_W-1:0] hold_pc;
  int unsigned     bub     = 0;
  logic [PC_W-1:0] pc_ctr  = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bubbles expected right after reset release: the first edge is idle.
  function automatic int unsigned bub_after_reset();
`ifdef FD_BUBBLE_CNT_EN
    return 1;
`else
    return 0;
`endif
  endfunction

  // Offer one cycle of inputs (applied at the next rising edge) and update
  // the reference model: words pair up opcode+immediate, flush drops all.
  task automatic drive(bit v, logic [15:0] w, logic [PC_W-1:0] pc, bit st, bit fl);
    bit acc, vnext;
    @(posedge clk); #1;
    check("bubble_cnt", 64'(fd.bubble_cnt), 64'(bub));
    fd.in_valid = v; fd.in_word = w; fd.in_pc = pc; fd.stall = st; fd.flush = fl;
    acc   = v && (!st || fl);
    vnext = acc && !fl && (pend || w[15:14] != 2'b11);
`ifdef FD_BUBBLE_CNT_EN
    if ((!st || fl) && !vnext && bub != (2**BCNT_W) - 1) bub++;
`endif
    if (fl) pend = 1'b0;
    else if (acc) begin
      if (pend) begin
        q.push_back('{hold_w, w, hold_pc});
        pend = 1'b0;
      end else if (w[15:14] == 2'b11) begin
        pend = 1'b1; hold_w = w; hold_pc = pc;
      end else begin
        q.push_back('{w, 16'h0, pc});
      end
    end
  endtask

  // Pull reset low between edges and check the outputs clear with no edge.
  task automatic reset_mid();
    @(posedge clk); #2;
    rst = 1'b0;
    fd.in_valid = 1'b0; fd.stall = 1'b0; fd.flush = 1'b0;
    #1;
    check("async_rst_valid", 64'(fd.out_valid), 64'd0);
    check("async_rst_instr", 64'(fd.out_instr), 64'd0);
    check("async_rst_pc",    64'(fd.out_pc),    64'd0);
    q.delete(); pend = 1'b0; bub = bub_after_reset();
    #1 rst = 1'b1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("in_ready", 64'(fd.in_ready), 64'(!fd.stall || fd.flush));
      if (fd.out_valid && fd.in_ready) begin
        if (q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_output: got instr %0h expected none", fd.out_instr);
        end else begin
          e = q.pop_front();
          check("out_instr", 64'(fd.out_instr), 64'(e.instr));
          check("out_imm",   64'(fd.out_imm),   64'(e.imm));
          check("out_pc",    64'(fd.out_pc),    64'(e.pc));
          check("read_addr1", 64'(fd.out_read_addr1), 64'({2'b00, e.instr[10:8]}));
          check("read_addr2", 64'(fd.out_read_addr2), 64'({2'b00, e.instr[7:5]}));
        end
      end
    end
  end

  initial begin
    fd.in_valid = 1'b0; fd.in_word = '0; fd.in_pc = '0;
    fd.stall = 1'b0; fd.flush = 1'b0;
    #1;
    check("rst_valid",  64'(fd.out_valid),  64'd0);
    check("rst_instr",  64'(fd.out_instr),  64'd0);
    check("rst_imm",    64'(fd.out_imm),    64'd0);
    check("rst_pc",     64'(fd.out_pc),     64'd0);
    check("rst_bubble", 64'(fd.bubble_cnt), 64'd0);
    check("rst_ready",  64'(fd.in_ready),   64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    bub = bub_after_reset();

    // single-word stream
    drive(1, 16'h1234, 0, 0, 0);
    drive(1, 16'h0520, 1, 0, 0);
    // two-word instruction
    drive(1, 16'hC108, 4, 0, 0);
    drive(1, 16'hBEEF, 5, 0, 0);
    // stall 3 cycles with 1234 on the outputs
    drive(1, 16'h1234, 6, 0, 0);
    repeat (3) drive(1, 16'h1111, 7, 1, 0);
    drive(1, 16'h1111, 7, 0, 0);
    drive(0, 16'h0, 0, 0, 0);
    // flush in S_IMM
    drive(1, 16'hC108, 8, 0, 0);
    drive(1, 16'hBEEF, 9, 0, 1);
    drive(1, 16'h1234, 10, 0, 0);
    // flush and stall together: flush wins
    drive(1, 16'hC108, 11, 0, 0);
    drive(1, 16'hBEEF, 12, 1, 1);
    drive(1, 16'h0520, 13, 0, 0);
    // async reset with an instruction on the outputs
    drive(1, 16'h1234, 14, 0, 0);
    reset_mid();
    // async reset mid-S_IMM; next word must be decoded as an opcode word
    drive(1, 16'hC108, 15, 0, 0);
    reset_mid();
    drive(1, 16'hBEEF, 16, 0, 0);
    drive(0, 16'h0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 99) < 30) w[15:14] = 2'b11;
      drive($urandom_range(0, 99) < 70, w, pc_ctr,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8);
      pc_ctr = pc_ctr + 1;
    end

    repeat (4) drive(0, 16'h0, 0, 0, 0);
    @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
